// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   localparam int SUB_DEFAULT_N = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_if
   import sub_pkg::*;
#(
   parameter int N = SUB_DEFAULT_N
);
   logic         start_valid;
   logic         start_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [N-1:0] diff;
   logic         bout;
`ifdef SUB_OVF_EN
   logic         ovf;
`endif
   logic         done_valid;
   logic         done_ready;

`ifdef SUB_OVF_EN
   // Operand source / result sink side
   modport master (
      output start_valid, a, b, done_ready,
      input  start_ready, diff, bout, ovf, done_valid
   );
   // Subtractor side
   modport slave (
      input  start_valid, a, b, done_ready,
      output start_ready, diff, bout, ovf, done_valid
   );
`else
   // Operand source / result sink side
   modport master (
      output start_valid, a, b, done_ready,
      input  start_ready, diff, bout, done_valid
   );
   // Subtractor side
   modport slave (
      input  start_valid, a, b, done_ready,
      output start_ready, diff, bout, done_valid
   );
`endif

endinterface

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor: d = x - y - borrow_in, bo = borrow out.
module fs (
   input  logic xi,
   input  logic yi,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = xi ^ yi ^ bi;
   assign bo = (~xi & yi) | (~(xi ^ yi) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first through a
// single registered borrow. Operands and result move over valid/ready.
// Optional signed-overflow flag is built when SUB_OVF_EN is defined.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int N = SUB_DEFAULT_N
) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);

   // Counter needs at least one bit even for N = 1
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   sub_state_t     state;
   sub_state_t     state_next;
   logic [CNT_W-1:0] cnt;
   logic           br;
   logic           br_next;
   logic           d;
   logic           last;
   logic [N-1:0]   a_sh;
   logic [N-1:0]   b_sh;
   logic [N-1:0]   diff_sh;
   logic [N-1:0]   diff_next;
   logic           start_ready;
   logic           done_valid;

   assign last = (cnt == LAST);

   fs u_fs (
      .xi (a_sh[0]),
      .yi (b_sh[0]),
      .bi (br),
      .d  (d),
      .bo (br_next)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_next  = state;
      start_ready = 1'b0;
      done_valid  = 1'b0;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (bus.start_valid) state_next = SHIFT;
         end
         SHIFT: begin
            if (last) state_next = DONE;
         end
         DONE: begin
            done_valid = 1'b1;
            if (bus.done_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // New result bit enters at the MSB, earlier bits move toward the LSB
   always_comb begin
      diff_next        = diff_sh >> 1;
      diff_next[N-1]   = d;
   end

   // Operand shift registers: loaded on acceptance, drained one bit per SHIFT cycle
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.start_valid) begin
         a_sh <= bus.a;
         b_sh <= bus.b;
      end else if (state == SHIFT) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
      end
   end

   // Counter, borrow and result registers; result survives IDLE until next op
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         br      <= 1'b0;
         diff_sh <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_valid) begin
                  cnt <= '0;
                  br  <= 1'b0;
               end
            end
            SHIFT: begin
               diff_sh <= diff_next;
               br      <= br_next;
               if (!last) cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SUB_OVF_EN
   logic ovf_q;

   // On the last SHIFT cycle a_sh[0]/b_sh[0] are the operand sign bits and d is the result sign
   always_ff @(posedge clk) begin
      if (rst)                      ovf_q <= 1'b0;
      else if (state == SHIFT && last) ovf_q <= (a_sh[0] != b_sh[0]) && (d != a_sh[0]);
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.start_ready = start_ready;
   assign bus.done_valid  = done_valid;
   assign bus.diff        = diff_sh;
   assign bus.bout        = br;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: an N=8 instance driven
// from a vector table plus stall/reset sequences, and an N=1 instance.
// Overflow checks are compiled in when SUB_OVF_EN is defined.
module tb_serial_subtractor;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   serial_subtractor_if #(.N(8)) bus8 ();
   serial_subtractor_if #(.N(1)) bus1 ();

   serial_subtractor #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_subtractor #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t vecs [9];
   vec_t v1   [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One complete N=8 transaction; operands change right after acceptance
   task automatic op8(input string tag, input vec_t v);
      int lat;
      bus8.a           = v.a;
      bus8.b           = v.b;
      bus8.start_valid = 1'b1;
      check({tag, " start_ready"}, 32'(bus8.start_ready), 32'd1);
      @(posedge clk); #1;
      bus8.start_valid = 1'b0;
      bus8.a           = ~v.a;
      bus8.b           = ~v.b;
      lat = 1;
      while (!bus8.done_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd9);
      check({tag, " diff"}, 32'(bus8.diff), 32'(v.diff));
      check({tag, " bout"}, 32'(bus8.bout), 32'(v.bout));
`ifdef SUB_OVF_EN
      check({tag, " ovf"}, 32'(bus8.ovf), 32'(v.ovf));
`endif
      bus8.done_ready = 1'b1;
      @(posedge clk); #1;
      bus8.done_ready = 1'b0;
      check({tag, " idle start_ready"}, 32'(bus8.start_ready), 32'd1);
      check({tag, " idle done_valid"}, 32'(bus8.done_valid), 32'd0);
      check({tag, " idle diff kept"}, 32'(bus8.diff), 32'(v.diff));
   endtask

   // One complete N=1 transaction
   task automatic op1(input string tag, input vec_t v);
      int lat;
      bus1.a           = v.a[0];
      bus1.b           = v.b[0];
      bus1.start_valid = 1'b1;
      @(posedge clk); #1;
      bus1.start_valid = 1'b0;
      bus1.a           = ~v.a[0];
      bus1.b           = ~v.b[0];
      lat = 1;
      while (!bus1.done_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd2);
      check({tag, " diff"}, 32'(bus1.diff), 32'(v.diff[0]));
      check({tag, " bout"}, 32'(bus1.bout), 32'(v.bout));
`ifdef SUB_OVF_EN
      check({tag, " ovf"}, 32'(bus1.ovf), 32'(v.ovf));
`endif
      bus1.done_ready = 1'b1;
      @(posedge clk); #1;
      bus1.done_ready = 1'b0;
      check({tag, " idle start_ready"}, 32'(bus1.start_ready), 32'd1);
   endtask

   initial begin
      int wait_cnt;
      checks = 0;
      errors = 0;

      //                a      b      diff   bout  ovf
      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
      vecs[6] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
      vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[8] = '{8'h12, 8'h34, 8'hDE, 1'b1, 1'b0};

      v1[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      v1[1] = '{8'h00, 8'h01, 8'h01, 1'b1, 1'b1};
      v1[2] = '{8'h01, 8'h00, 8'h01, 1'b0, 1'b0};
      v1[3] = '{8'h01, 8'h01, 8'h00, 1'b0, 1'b0};

      rst              = 1'b1;
      bus8.start_valid = 1'b0;
      bus8.done_ready  = 1'b0;
      bus8.a           = '0;
      bus8.b           = '0;
      bus1.start_valid = 1'b0;
      bus1.done_ready  = 1'b0;
      bus1.a           = '0;
      bus1.b           = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("reset start_ready", 32'(bus8.start_ready), 32'd1);
      check("reset done_valid", 32'(bus8.done_valid), 32'd0);
      check("reset diff", 32'(bus8.diff), 32'd0);
      check("reset bout", 32'(bus8.bout), 32'd0);
`ifdef SUB_OVF_EN
      check("reset ovf", 32'(bus8.ovf), 32'd0);
`endif
      check("reset n1 start_ready", 32'(bus1.start_ready), 32'd1);
      check("reset n1 diff", 32'(bus1.diff), 32'd0);

      for (int i = 0; i < 9; i++) op8($sformatf("vec%0d", i), vecs[i]);

      // Result stall: done_ready low for 20 cycles, start_valid pulses ignored
      bus8.a           = 8'h3C;
      bus8.b           = 8'h0F;
      bus8.start_valid = 1'b1;
      @(posedge clk); #1;
      bus8.start_valid = 1'b0;
      wait_cnt = 0;
      while (!bus8.done_valid && wait_cnt < 40) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      check("stall reached done", 32'(bus8.done_valid), 32'd1);
      for (int c = 0; c < 20; c++) begin
         bus8.start_valid = c[0];
         bus8.a           = 8'hFF;
         bus8.b           = 8'h00;
         @(posedge clk); #1;
         check($sformatf("stall%0d diff", c), 32'(bus8.diff), 32'h2D);
         check($sformatf("stall%0d done_valid", c), 32'(bus8.done_valid), 32'd1);
         check($sformatf("stall%0d start_ready", c), 32'(bus8.start_ready), 32'd0);
      end
      bus8.start_valid = 1'b0;
      check("stall bout", 32'(bus8.bout), 32'd0);
      bus8.done_ready = 1'b1;
      @(posedge clk); #1;
      bus8.done_ready = 1'b0;
      check("release start_ready", 32'(bus8.start_ready), 32'd1);
      check("release done_valid", 32'(bus8.done_valid), 32'd0);
      @(posedge clk); #1;
      check("release stays idle", 32'(bus8.start_ready), 32'd1);
      check("release diff kept", 32'(bus8.diff), 32'h2D);

      // Reset in the 4th SHIFT cycle aborts the operation
      bus8.a           = 8'hA5;
      bus8.b           = 8'h5A;
      bus8.start_valid = 1'b1;
      @(posedge clk); #1;
      bus8.start_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid shift busy", 32'(bus8.start_ready), 32'd0);
      rst              = 1'b1;
      bus8.start_valid = 1'b1;
      @(posedge clk); #1;
      rst              = 1'b0;
      bus8.start_valid = 1'b0;
      check("abort start_ready", 32'(bus8.start_ready), 32'd1);
      check("abort done_valid", 32'(bus8.done_valid), 32'd0);
      check("abort diff", 32'(bus8.diff), 32'd0);
      check("abort bout", 32'(bus8.bout), 32'd0);
      repeat (10) @(posedge clk);
      #1;
      check("abort no late done", 32'(bus8.done_valid), 32'd0);
      op8("after abort", vecs[3]);

      for (int i = 0; i < 4; i++) op1($sformatf("n1 ab%0d", i), v1[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
